// File: rtl/soda_machine_types.sv
// Shared types and timing defaults for the soda dispense sequencer.
// The optional cup sensor is enabled with SODA_CUP_SENSE_EN.
package soda_machine_types;

    typedef enum logic [2:0] {
        IDLE,
        KICK1,
        WAIT1,
        KICK2,
        WAIT2,
        POUR,
        FAULT
    } dispense_state_type;

    localparam int DEF_KICK_CYCLES  = 8;
    localparam int DEF_COIN_TIMEOUT = 1000;
    localparam int DEF_MAX_RETRY    = 2;
    localparam int DEF_POUR_CYCLES  = 5000;
    localparam int DEF_PEND_W       = 4;

    // Timer is loaded with duration-1, so $clog2 of the longest duration fits.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/soda_timer.sv
// Loadable down-counter shared by all timed states of the sequencer.
// done is high whenever the count has reached zero.
module soda_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/soda_dispense_sequencer.sv
// Queues coin ejections and pours from the vending FSM and runs the
// hopper/valve actuators one job at a time. Option: SODA_CUP_SENSE_EN.
module soda_dispense_sequencer
    import soda_machine_types::*;
#(
    parameter int KICK_CYCLES  = DEF_KICK_CYCLES,
    parameter int COIN_TIMEOUT = DEF_COIN_TIMEOUT,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int POUR_CYCLES  = DEF_POUR_CYCLES,
    parameter int PEND_W       = DEF_PEND_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pour_water,
    input  logic change1,
    input  logic change2,
    input  logic change22,
    input  logic coin_seen,
`ifdef SODA_CUP_SENSE_EN
    input  logic cup_present,
`endif
    output logic hopper1_kick,
    output logic hopper2_kick,
    output logic valve_open,
    output logic busy,
    output logic fault,
    output logic overflow
);

    localparam int TW = timer_width(KICK_CYCLES, COIN_TIMEOUT, POUR_CYCLES);
    localparam int CW = PEND_W + 2;
    localparam logic [CW-1:0] PMAX = CW'((1 << PEND_W) - 1);
    localparam logic [TW-1:0] T_KICK = TW'(KICK_CYCLES - 1);
    localparam logic [TW-1:0] T_WAIT = TW'(COIN_TIMEOUT - 1);
    localparam logic [TW-1:0] T_POUR = TW'(POUR_CYCLES - 1);
    localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);

    dispense_state_type state_q, state_d;
    logic [PEND_W-1:0] c1_q, c2_q, pw_q;
    logic [CW-1:0] n1, n2, np;
    logic [7:0] retry_q, retry_d;
    logic [2:0] coin_q;
    logic coin_edge, cup_ok;
    logic t_load, t_en, t_done;
    logic [TW-1:0] t_val;
    logic dec1, dec2, decp;
    logic hop1_q, hop2_q, valve_q, ovf_q;

`ifdef SODA_CUP_SENSE_EN
    logic [1:0] cup_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cup_q <= '0;
        else cup_q <= {cup_q[0], cup_present};
    end

    assign cup_ok = cup_q[1];
`else
    assign cup_ok = 1'b1;
`endif

    assign coin_edge = coin_q[1] & ~coin_q[2];

    soda_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (t_load),
        .en      (t_en),
        .value   (t_val),
        .done    (t_done)
    );

    // Net per-cycle change; saturation is judged after the job's decrement.
    assign n1 = CW'(c1_q) + CW'(change1) - CW'(dec1);
    assign n2 = CW'(c2_q) + CW'(change2) + CW'({change22, 1'b0}) - CW'(dec2);
    assign np = CW'(pw_q) + CW'(pour_water) - CW'(decp);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        t_load  = 1'b0;
        t_en    = 1'b0;
        t_val   = '0;
        dec1    = 1'b0;
        dec2    = 1'b0;
        decp    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (c1_q != '0) begin
                    state_d = KICK1;
                    t_load  = 1'b1;
                    t_val   = T_KICK;
                end else if (c2_q != '0) begin
                    state_d = KICK2;
                    t_load  = 1'b1;
                    t_val   = T_KICK;
                end else if ((pw_q != '0) && cup_ok) begin
                    state_d = POUR;
                    t_load  = 1'b1;
                    t_val   = T_POUR;
                end
            end
            KICK1, KICK2: begin
                if (t_done) begin
                    state_d = (state_q == KICK1) ? WAIT1 : WAIT2;
                    t_load  = 1'b1;
                    t_val   = T_WAIT;
                end else begin
                    t_en = 1'b1;
                end
            end
            WAIT1, WAIT2: begin
                if (coin_edge) begin
                    dec1    = (state_q == WAIT1);
                    dec2    = (state_q == WAIT2);
                    retry_d = '0;
                    state_d = IDLE;
                end else if (t_done) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 8'd1;
                        state_d = (state_q == WAIT1) ? KICK1 : KICK2;
                        t_load  = 1'b1;
                        t_val   = T_KICK;
                    end else begin
                        state_d = FAULT;
                    end
                end else begin
                    t_en = 1'b1;
                end
            end
            POUR: begin
                if (t_done && cup_ok) begin
                    decp    = 1'b1;
                    state_d = IDLE;
                end else begin
                    t_en = cup_ok;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            retry_q <= '0;
            coin_q  <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            pw_q    <= '0;
            hop1_q  <= 1'b0;
            hop2_q  <= 1'b0;
            valve_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            coin_q  <= {coin_q[1:0], coin_seen};
            c1_q    <= (n1 > PMAX) ? '1 : n1[PEND_W-1:0];
            c2_q    <= (n2 > PMAX) ? '1 : n2[PEND_W-1:0];
            pw_q    <= (np > PMAX) ? '1 : np[PEND_W-1:0];
            hop1_q  <= (state_q == KICK1);
            hop2_q  <= (state_q == KICK2);
            valve_q <= (state_q == POUR) && cup_ok;
            ovf_q   <= (n1 > PMAX) || (n2 > PMAX) || (np > PMAX);
        end
    end

    assign hopper1_kick = hop1_q;
    assign hopper2_kick = hop2_q;
    assign valve_open   = valve_q;
    assign overflow     = ovf_q;
    assign fault        = (state_q == FAULT);
    assign busy         = (state_q != FAULT) &&
                          ((state_q != IDLE) || ({c1_q, c2_q, pw_q} != '0));

endmodule

// File: tb/tb_soda_dispense_sequencer.sv
// Scoreboard bench: bursts of requests are turned into an expected list of
// actuator pulses; a monitor pops and compares each pulse as it ends.
module tb_soda_dispense_sequencer;

    localparam int KICK  = 8;
    localparam int TMO   = 20;
    localparam int RETRY = 2;
    localparam int POUR  = 50;
    localparam int PMAX  = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic pour_water = 1'b0;
    logic change1 = 1'b0;
    logic change2 = 1'b0;
    logic change22 = 1'b0;
    logic coin_seen = 1'b0;
`ifdef SODA_CUP_SENSE_EN
    logic cup_present = 1'b1;
`endif
    logic hopper1_kick, hopper2_kick, valve_open, busy, fault, overflow;

    typedef struct {
        int kind;
        int width;
    } ev_t;

    typedef struct {
        bit deliver;
        int delay;
    } plan_t;

    ev_t   exp_q[$];
    plan_t plan_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    ov_seen = 0;
    int    wid[3];
    bit    last_fault;
    bit    rq1[32], rq2[32], rq22[32], rqp[32];

    always #5 clk = ~clk;

    soda_dispense_sequencer #(
        .KICK_CYCLES  (KICK),
        .COIN_TIMEOUT (TMO),
        .MAX_RETRY    (RETRY),
        .POUR_CYCLES  (POUR),
        .PEND_W       (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pour_water   (pour_water),
        .change1      (change1),
        .change2      (change2),
        .change22     (change22),
        .coin_seen    (coin_seen),
`ifdef SODA_CUP_SENSE_EN
        .cup_present  (cup_present),
`endif
        .hopper1_kick (hopper1_kick),
        .hopper2_kick (hopper2_kick),
        .valve_open   (valve_open),
        .busy         (busy),
        .fault        (fault),
        .overflow     (overflow)
    );

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    function automatic ev_t mk(input int kind, input int width);
        ev_t e;
        e.kind  = kind;
        e.width = width;
        return e;
    endfunction

    task automatic pulse_end(input int kind, input int width);
        ev_t e;
        check(exp_q.size() != 0, "pulse_expected", kind, 0);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check(e.kind == kind, "pulse_kind", kind, e.kind);
        check(e.width == width, "pulse_width", width, e.width);
    endtask

    // Monitor: kinds 1=hopper1, 2=hopper2, 3=valve.
    always @(negedge clk) begin : mon
        logic [2:0] act;
        act = {valve_open, hopper2_kick, hopper1_kick};
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) wid[k] = 0;
        end else begin
            if (act != 3'b000)
                check($countones(act) == 1, "one_actuator", $countones(act), 1);
            if (overflow) ov_seen++;
            for (int k = 0; k < 3; k++) begin
                if (act[k]) begin
                    wid[k]++;
                end else if (wid[k] != 0) begin
                    pulse_end(k + 1, wid[k]);
                    wid[k] = 0;
                end
            end
        end
    end

    // Hopper/chute model: each finished kick consumes one plan entry.
    initial begin : hopper
        logic  prev;
        plan_t p;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = 1'b0;
            end else begin
                if (prev && !(hopper1_kick || hopper2_kick)) begin
                    check(plan_q.size() != 0, "coin_plan", 0, 1);
                    if (plan_q.size() != 0) begin
                        p = plan_q.pop_front();
                        if (p.deliver) begin
                            repeat (p.delay) @(negedge clk);
                            coin_seen = 1'b1;
                            repeat (3) @(negedge clk);
                            coin_seen = 1'b0;
                        end
                    end
                end
                prev = hopper1_kick || hopper2_kick;
            end
        end
    end

    task automatic clr();
        for (int i = 0; i < 32; i++) begin
            rq1[i] = 0;
            rq2[i] = 0;
            rq22[i] = 0;
            rqp[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        plan_q.delete();
        repeat (3) @(negedge clk);
        check({hopper1_kick, hopper2_kick, valve_open, busy, fault, overflow} == 6'b0,
              "reset_outputs",
              int'({hopper1_kick, hopper2_kick, valve_open, busy, fault, overflow}), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Burst rq*[0..len-1] must have a request in slot 0; dly=0 picks random delays.
    task automatic run_case(input int len, input int dly, input int fail_pct);
        int  c[3];
        int  ov, first, n;
        int  jobs[$];
        bit  exp_fault;
        c[0] = 0;
        c[1] = 0;
        c[2] = 0;
        ov = 0;
        for (int i = 0; i < len; i++) begin
            int add[3];
            bit sat;
            add[0] = rq1[i];
            add[1] = rq2[i] + 2 * rq22[i];
            add[2] = rqp[i];
            sat = 0;
            for (int k = 0; k < 3; k++) begin
                if (c[k] + add[k] > PMAX) begin
                    c[k] = PMAX;
                    sat = 1;
                end else begin
                    c[k] += add[k];
                end
            end
            if (sat) ov++;
        end
        if (rq1[0]) first = 0;
        else if (rq2[0] || rq22[0]) first = 1;
        else first = 2;
        jobs.push_back(first);
        c[first]--;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < c[k]; j++) jobs.push_back(k);
        exp_fault = 0;
        for (int j = 0; j < jobs.size(); j++) begin
            if (exp_fault) break;
            if (jobs[j] == 2) begin
                exp_q.push_back(mk(3, POUR));
            end else begin
                for (int a = 0; a <= RETRY; a++) begin
                    plan_t p;
                    p.deliver = ($urandom_range(99) >= fail_pct);
                    if (dly != 0) p.delay = dly;
                    else if (j == 0 && len > 8) p.delay = 12;
                    else p.delay = $urandom_range(1, 12);
                    plan_q.push_back(p);
                    exp_q.push_back(mk(jobs[j] + 1, KICK));
                    if (p.deliver) break;
                    if (a == RETRY) exp_fault = 1;
                end
            end
        end
        ov_seen = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            change1 = rq1[i];
            change2 = rq2[i];
            change22 = rq22[i];
            pour_water = rqp[i];
        end
        @(negedge clk);
        {change1, change2, change22, pour_water} = 4'b0;
        check(busy == 1'b1, "busy_after_burst", int'(busy), 1);
        n = 0;
        while (busy && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check(n < 10000, "drain_in_time", n, 10000);
        repeat (8) @(negedge clk);
        check(exp_q.size() == 0, "pulses_missing", exp_q.size(), 0);
        check(plan_q.size() == 0, "kicks_missing", plan_q.size(), 0);
        check(fault == exp_fault, "fault", int'(fault), int'(exp_fault));
        check(ov_seen == ov, "overflow_cycles", ov_seen, ov);
        check(busy == 1'b0, "busy_idle", int'(busy), 0);
        exp_q.delete();
        plan_q.delete();
        last_fault = exp_fault;
    endtask

    initial begin
        int n;
        do_reset();

        clr(); rq1[0] = 1;
        run_case(1, 5, 0);

        clr(); rq22[0] = 1; rqp[0] = 1;
        run_case(1, 3, 0);

        clr(); rq1[0] = 1; rq2[0] = 1;
        run_case(1, 0, 0);

        clr();
        for (int i = 0; i < 16; i++) rq1[i] = 1;
        run_case(16, 0, 0);

        clr(); rq2[0] = 1;
        run_case(1, 0, 100);
        @(negedge clk); pour_water = 1'b1;
        @(negedge clk); pour_water = 1'b0;
        repeat (100) @(negedge clk);
        check(fault == 1'b1, "fault_sticky", int'(fault), 1);
        check(valve_open == 1'b0, "valve_in_fault", int'(valve_open), 0);
        check(busy == 1'b0, "busy_in_fault", int'(busy), 0);
        do_reset();

        @(negedge clk); pour_water = 1'b1;
        @(negedge clk); pour_water = 1'b0;
        n = 0;
        while (!valve_open && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(valve_open == 1'b1, "valve_opens", int'(valve_open), 1);
        repeat (10) @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check(valve_open == 1'b0, "valve_async_drop", int'(valve_open), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        check(valve_open == 1'b0, "valve_after_reset", int'(valve_open), 0);
        check(busy == 1'b0, "busy_after_reset", int'(busy), 0);

        for (int t = 0; t < 12; t++) begin
            int len;
            clr();
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                rq1[i]  = ($urandom_range(3) == 0);
                rq2[i]  = ($urandom_range(3) == 0);
                rq22[i] = ($urandom_range(4) == 0);
                rqp[i]  = ($urandom_range(4) == 0);
            end
            if (!(rq1[0] || rq2[0] || rq22[0] || rqp[0])) begin
                case ($urandom_range(3))
                    0: rq1[0] = 1;
                    1: rq2[0] = 1;
                    2: rq22[0] = 1;
                    default: rqp[0] = 1;
                endcase
            end
            run_case(len, 0, 8);
            if (last_fault) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
